obi_sram_responder: RTL and testbench

OBI_SRAM_RESPONDER -- requirements
Module: obi_sram_responder

---
 rtl/cei_mochila_pkg.sv | 17 +
 rtl/obi_pkg.sv | 18 +
 rtl/obi_sram_responder.sv | 175 +++++++++++++++++
 tb/tb_obi_sram_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cei_mochila_pkg.sv
// SoC-level constants: SRAM bank placement and the error read pattern.
package cei_mochila_pkg;

    localparam logic [31:0] ERR_RDATA      = 32'hBADC_AB1E;
    localparam logic [31:0] SRAM_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned SRAM_NUM_WORDS = 1024;

    function automatic logic [31:0] bank_offset(input logic [31:0] addr, input logic [31:0] base);
        return addr - base;
    endfunction

    // 34-bit compare so a bank spanning the whole 32-bit space cannot overflow the limit.
    function automatic logic bank_in_range(input logic [31:0] offset, input int unsigned num_words);
        return {2'b00, offset} < {num_words, 2'b00};
    endfunction

endpackage

// File: rtl/obi_pkg.sv
// OBI bus request/response types shared by crossbar masters and slaves.
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/obi_sram_responder.sv
// OBI slave in front of a single-port SRAM bank: one outstanding transaction,
// configurable extra response latency, out-of-range accesses answered with an error pattern.
module obi_sram_responder
    import obi_pkg::*;
    import cei_mochila_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int unsigned NUM_WORDS   = SRAM_NUM_WORDS,
    parameter int unsigned WAIT_CYCLES = 0,
    localparam int unsigned AW         = $clog2(NUM_WORDS)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  obi_req_t      bus_req_i,
    output obi_resp_t     bus_resp_o,
    output logic          sram_req_o,
    output logic          sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [3:0]    sram_be_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i,
    output logic [7:0]    err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_write_q, is_write_d;
    logic        is_err_q, is_err_d;
    logic        capture_q, capture_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    logic [31:0] offset_s;
    logic        in_range_s;
    logic        gnt_s;
    logic        accept_s;
    logic        sram_req_s;
    logic        rvalid_s;
    logic [31:0] read_data_s;

    assign offset_s   = bank_offset(bus_req_i.addr, BASE_ADDR);
    assign in_range_s = bank_in_range(offset_s, NUM_WORDS);

    // Grant: a new transaction may start when idle or while the previous one is being answered.
    always_comb begin
        gnt_s = 1'b0;
        if (rst_i) begin
            gnt_s = 1'b0;
        end else if ((state_q == IDLE) || ((state_q == RESP) && (cnt_q == 3'd0))) begin
            gnt_s = bus_req_i.req;
        end else begin
            gnt_s = 1'b0;
        end
    end

    assign accept_s   = gnt_s & bus_req_i.req;
    assign sram_req_s = accept_s & in_range_s;

    // Next-state logic for the transaction FSM and its side registers.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        is_err_d   = is_err_q;
        capture_d  = accept_s;
        rdata_d    = rdata_q;
        err_cnt_d  = err_cnt_q;

        // SRAM data is only valid in the cycle after the strobe, so it is held for slow responses.
        if (capture_q && !is_write_q && !is_err_q) begin
            rdata_d = sram_rdata_i;
        end else begin
            rdata_d = rdata_q;
        end

        if (accept_s && !in_range_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end

        case (state_q)
            IDLE, RESP: begin
                if (accept_s) begin
                    state_d    = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt_d      = WAIT_LOAD;
                    is_write_d = bus_req_i.we;
                    is_err_d   = ~in_range_s;
                end else begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // State and side registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            is_write_q <= 1'b0;
            is_err_q   <= 1'b0;
            capture_q  <= 1'b0;
            rdata_q    <= 32'h0;
            err_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            is_err_q   <= is_err_d;
            capture_q  <= capture_d;
            rdata_q    <= rdata_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rvalid_s    = ~rst_i & (state_q == RESP);
    assign read_data_s = capture_q ? sram_rdata_i : rdata_q;

    // Response channel: data is forced to zero outside the response cycle.
    always_comb begin
        bus_resp_o.gnt    = gnt_s;
        bus_resp_o.rvalid = rvalid_s;
        bus_resp_o.rdata  = 32'h0;
        if (!rvalid_s) begin
            bus_resp_o.rdata = 32'h0;
        end else if (is_err_q) begin
            bus_resp_o.rdata = ERR_RDATA;
        end else if (is_write_q) begin
            bus_resp_o.rdata = 32'h0;
        end else begin
            bus_resp_o.rdata = read_data_s;
        end
    end

    // SRAM port: everything quiet unless an in-range access is accepted this cycle.
    always_comb begin
        sram_req_o   = sram_req_s;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = 4'b0000;
        sram_wdata_o = 32'h0;
        if (sram_req_s) begin
            sram_we_o    = bus_req_i.we;
            sram_addr_o  = offset_s[AW+1:2];
            sram_be_o    = bus_req_i.be;
            sram_wdata_o = bus_req_i.wdata;
        end else begin
            sram_we_o = 1'b0;
        end
    end

    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_obi_sram_responder.sv
// Directed bench: one responder with no wait states and one with three, each backed by a small SRAM model.
module tb_obi_sram_responder;
    import obi_pkg::*;

    localparam logic [31:0] B0 = 32'h1000_0000;

    logic      clk;
    logic      rst;
    obi_req_t  req0, req3;
    obi_resp_t resp0, resp3;

    logic        s0_req, s0_we;
    logic [3:0]  s0_addr;
    logic [3:0]  s0_be;
    logic [31:0] s0_wdata, s0_rdata;
    logic [7:0]  err0;

    logic        s3_req, s3_we;
    logic [9:0]  s3_addr;
    logic [3:0]  s3_be;
    logic [31:0] s3_wdata, s3_rdata;
    logic [7:0]  err3;

    logic [31:0] mem0 [16];
    logic [31:0] mem3 [1024];

    int n_checks = 0;
    int n_errors = 0;

    obi_sram_responder #(.BASE_ADDR(B0), .NUM_WORDS(16), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .bus_req_i(req0), .bus_resp_o(resp0),
        .sram_req_o(s0_req), .sram_we_o(s0_we), .sram_addr_o(s0_addr), .sram_be_o(s0_be),
        .sram_wdata_o(s0_wdata), .sram_rdata_i(s0_rdata), .err_cnt_o(err0)
    );

    obi_sram_responder #(.BASE_ADDR(32'h0), .NUM_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
        .clk_i(clk), .rst_i(rst), .bus_req_i(req3), .bus_resp_o(resp3),
        .sram_req_o(s3_req), .sram_we_o(s3_we), .sram_addr_o(s3_addr), .sram_be_o(s3_be),
        .sram_wdata_o(s3_wdata), .sram_rdata_i(s3_rdata), .err_cnt_o(err3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM models: read data valid one cycle after a read strobe, junk otherwise.
    always @(posedge clk) begin
        if (s0_req && s0_we) begin
            for (int b = 0; b < 4; b++) if (s0_be[b]) mem0[s0_addr][8*b +: 8] <= s0_wdata[8*b +: 8];
        end
        s0_rdata <= (s0_req && !s0_we) ? mem0[s0_addr] : 32'hDEAD_DEAD;
        if (s3_req && s3_we) begin
            for (int b = 0; b < 4; b++) if (s3_be[b]) mem3[s3_addr][8*b +: 8] <= s3_wdata[8*b +: 8];
        end
        s3_rdata <= (s3_req && !s3_we) ? mem3[s3_addr] : 32'hDEAD_DEAD;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set0(input logic r, input logic w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
        req0.req = r; req0.we = w; req0.be = be; req0.addr = a; req0.wdata = d;
    endtask

    task automatic set3(input logic r, input logic w, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
        req3.req = r; req3.we = w; req3.be = be; req3.addr = a; req3.wdata = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem0[i] = 32'h0;
        for (int i = 0; i < 1024; i++) mem3[i] = 32'h0;
        rst = 1'b1;
        set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

        // Reset: a pending request must not be granted.
        tick(); set0(1'b1, 1'b0, 4'hF, B0, 32'h0); #1;
        check_eq("rst_gnt", 32'(resp0.gnt), 32'd0);
        check_eq("rst_rvalid", 32'(resp0.rvalid), 32'd0);
        check_eq("rst_sreq", 32'(s0_req), 32'd0);
        check_eq("rst_saddr", 32'(s0_addr), 32'd0);
        check_eq("rst_err", 32'(err0), 32'd0);

        // Write then read back, first accept right after reset.
        tick(); rst = 1'b0; set0(1'b1, 1'b1, 4'hF, B0 + 32'h8, 32'h1234_5678); #1;
        check_eq("w_gnt", 32'(resp0.gnt), 32'd1);
        check_eq("w_sreq", 32'(s0_req), 32'd1);
        check_eq("w_swe", 32'(s0_we), 32'd1);
        check_eq("w_saddr", 32'(s0_addr), 32'd2);
        check_eq("w_swdata", s0_wdata, 32'h1234_5678);
        check_eq("w_rvalid", 32'(resp0.rvalid), 32'd0);
        tick(); set0(1'b1, 1'b0, 4'hF, B0 + 32'h8, 32'h0); #1;
        check_eq("r_gnt", 32'(resp0.gnt), 32'd1);
        check_eq("w_resp_rvalid", 32'(resp0.rvalid), 32'd1);
        check_eq("w_resp_rdata", resp0.rdata, 32'h0);
        check_eq("r_swe", 32'(s0_we), 32'd0);
        tick(); set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        check_eq("r_rvalid", 32'(resp0.rvalid), 32'd1);
        check_eq("r_rdata", resp0.rdata, 32'h1234_5678);
        check_eq("idle_gnt", 32'(resp0.gnt), 32'd0);
        check_eq("idle_sreq", 32'(s0_req), 32'd0);
        check_eq("idle_swdata", s0_wdata, 32'h0);
        tick(); #1;
        check_eq("idle_rvalid", 32'(resp0.rvalid), 32'd0);
        check_eq("idle_rdata", resp0.rdata, 32'h0);

        // Back-to-back: two writes, three reads (last one unaligned), one per cycle.
        tick(); set0(1'b1, 1'b1, 4'hF, B0 + 32'h0, 32'h1111_1111);
        tick(); set0(1'b1, 1'b1, 4'hF, B0 + 32'h4, 32'h2222_2222);
        tick(); set0(1'b1, 1'b0, 4'hF, B0 + 32'h0, 32'h0); #1;
        check_eq("b2b_gnt0", 32'(resp0.gnt), 32'd1);
        tick(); set0(1'b1, 1'b0, 4'hF, B0 + 32'h4, 32'h0); #1;
        check_eq("b2b_gnt1", 32'(resp0.gnt), 32'd1);
        check_eq("b2b_rd0", resp0.rdata, 32'h1111_1111);
        tick(); set0(1'b1, 1'b0, 4'hF, B0 + 32'hB, 32'h0); #1;
        check_eq("b2b_gnt2", 32'(resp0.gnt), 32'd1);
        check_eq("unaligned_saddr", 32'(s0_addr), 32'd2);
        check_eq("b2b_rd1", resp0.rdata, 32'h2222_2222);
        tick(); set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        check_eq("b2b_rv2", 32'(resp0.rvalid), 32'd1);
        check_eq("b2b_rd2", resp0.rdata, 32'h1234_5678);
        tick(); #1;
        check_eq("b2b_end_rvalid", 32'(resp0.rvalid), 32'd0);

        // Range boundaries: last word, one past the end, and wrap below base.
        tick(); set0(1'b1, 1'b0, 4'hF, B0 + 32'd60, 32'h0); #1;
        check_eq("last_sreq", 32'(s0_req), 32'd1);
        check_eq("last_saddr", 32'(s0_addr), 32'd15);
        tick(); set0(1'b1, 1'b0, 4'hF, B0 + 32'd64, 32'h0); #1;
        check_eq("oor_gnt", 32'(resp0.gnt), 32'd1);
        check_eq("oor_sreq", 32'(s0_req), 32'd0);
        check_eq("last_rdata", resp0.rdata, 32'h0);
        tick(); set0(1'b1, 1'b0, 4'hF, B0 - 32'd4, 32'h0); #1;
        check_eq("wrap_sreq", 32'(s0_req), 32'd0);
        check_eq("oor_rdata", resp0.rdata, 32'hBADC_AB1E);
        check_eq("oor_err1", 32'(err0), 32'd1);
        tick(); set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        check_eq("wrap_rdata", resp0.rdata, 32'hBADC_AB1E);
        check_eq("wrap_err2", 32'(err0), 32'd2);

        // Byte enables, including an all-zero mask that still strobes.
        tick(); set0(1'b1, 1'b1, 4'hF, B0 + 32'hC, 32'hFFFF_FFFF);
        tick(); set0(1'b1, 1'b1, 4'b0010, B0 + 32'hC, 32'hAABB_CCDD); #1;
        check_eq("be2_sbe", 32'(s0_be), 32'h2);
        tick(); set0(1'b1, 1'b1, 4'b0000, B0 + 32'hC, 32'h0000_0000); #1;
        check_eq("be0_sreq", 32'(s0_req), 32'd1);
        check_eq("be0_sbe", 32'(s0_be), 32'h0);
        tick(); set0(1'b1, 1'b0, 4'hF, B0 + 32'hC, 32'h0);
        tick(); set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        check_eq("be_readback", resp0.rdata, 32'hFFFF_CCFF);

        // Error counter saturation.
        for (int i = 0; i < 260; i++) begin
            tick(); set0(1'b1, 1'b0, 4'hF, B0 + 32'h100, 32'h0);
        end
        tick(); set0(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        check_eq("err_sat", 32'(err0), 32'hFF);

        // Three wait states: held write, then held read answered from the capture register.
        tick(); set3(1'b1, 1'b1, 4'hF, 32'h14, 32'hCAFE_F00D); #1;
        check_eq("w3_gnt", 32'(resp3.gnt), 32'd1);
        check_eq("w3_sreq", 32'(s3_req), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            check_eq("w3_wait_gnt", 32'(resp3.gnt), 32'd0);
            check_eq("w3_wait_rvalid", 32'(resp3.rvalid), 32'd0);
        end
        tick(); set3(1'b1, 1'b0, 4'hF, 32'h14, 32'h0); #1;
        check_eq("w3_rvalid", 32'(resp3.rvalid), 32'd1);
        check_eq("w3_rdata", resp3.rdata, 32'h0);
        check_eq("w3_gnt_in_resp", 32'(resp3.gnt), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick(); #1;
            check_eq("r3_wait_gnt", 32'(resp3.gnt), 32'd0);
            check_eq("r3_wait_rvalid", 32'(resp3.rvalid), 32'd0);
        end
        tick(); set3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        check_eq("r3_rvalid", 32'(resp3.rvalid), 32'd1);
        check_eq("r3_rdata", resp3.rdata, 32'hCAFE_F00D);
        check_eq("r3_gnt", 32'(resp3.gnt), 32'd0);
        tick(); #1;
        check_eq("r3_done", 32'(resp3.rvalid), 32'd0);

        // Reset while waiting drops the transaction and clears the error count.
        tick(); set3(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0); #1;
        check_eq("rw_oor_gnt", 32'(resp3.gnt), 32'd1);
        check_eq("rw_oor_sreq", 32'(s3_req), 32'd0);
        tick(); set3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        check_eq("rw_err1", 32'(err3), 32'd1);
        tick(); rst = 1'b1; #1;
        check_eq("rw_rst_rvalid", 32'(resp3.rvalid), 32'd0);
        tick(); rst = 1'b0; set3(1'b1, 1'b0, 4'hF, 32'h14, 32'h0); #1;
        check_eq("rw_err0", 32'(err3), 32'd0);
        check_eq("rw_fresh_gnt", 32'(resp3.gnt), 32'd1);
        check_eq("rw_fresh_rvalid", 32'(resp3.rvalid), 32'd0);
        tick(); set3(1'b0, 1'b0, 4'h0, 32'h0, 32'h0); #1;
        check_eq("rw_norv1", 32'(resp3.rvalid), 32'd0);
        for (int i = 2; i <= 3; i++) begin
            tick(); #1;
            check_eq("rw_norv", 32'(resp3.rvalid), 32'd0);
        end
        tick(); #1;
        check_eq("rw_fresh_rv", 32'(resp3.rvalid), 32'd1);
        check_eq("rw_fresh_rdata", resp3.rdata, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
